// File: rtl/booth_mult_param.sv
// rtl/booth_mult_param.sv - sequential radix-2 Booth multiplier, WIDTH-bit operands, signed/unsigned select
module booth_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_value,
  input  logic [WIDTH-1:0]     b_value,
  output logic [2*WIDTH-1:0]   result,
  output logic                 done,
  output logic                 busy
);

  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(W1 + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W1 - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [W1-1:0] m_reg;
  logic [W1-1:0] a_reg;
  logic [W1-1:0] q_reg;
  logic          q_m1;
  logic [CW-1:0] count;

  logic [W1-1:0] a_step;
  logic [2*W1:0] shifted;
  logic [W1-1:0] a_ext;
  logic [W1-1:0] b_ext;
  logic          load;

  // The extra top bit lets unsigned operands ride through the signed Booth recoding unchanged.
  assign a_ext = signed_mode ? {a_value[WIDTH-1], a_value} : {1'b0, a_value};
  assign b_ext = signed_mode ? {b_value[WIDTH-1], b_value} : {1'b0, b_value};
  assign load  = start && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    a_step = a_reg;
    case ({q_reg[0], q_m1})
      2'b01:   a_step = a_reg + m_reg;
      2'b10:   a_step = a_reg - m_reg;
      default: a_step = a_reg;
    endcase
  end

  // {A,Q,q_m1} arithmetic right shift: new A = shifted[2*W1:W1+1], new Q = shifted[W1:1], new q_m1 = shifted[0].
  assign shifted = {a_step[W1-1], a_step, q_reg};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      m_reg  <= '0;
      a_reg  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      count  <= '0;
      result <= '0;
    end else if (load) begin
      state <= ST_RUN;
      m_reg <= a_ext;
      a_reg <= '0;
      q_reg <= b_ext;
      q_m1  <= 1'b0;
      count <= '0;
    end else if (state == ST_RUN) begin
      a_reg <= shifted[2*W1:W1+1];
      q_reg <= shifted[W1:1];
      q_m1  <= shifted[0];
      count <= count + CW'(1);
      if (count == LAST_STEP) begin
        result <= shifted[2*WIDTH:1];
        state  <= ST_DONE;
      end
    end
  end

  assign done = (state == ST_DONE);
  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_booth_mult_param.sv
// tb/tb_booth_mult_param.sv - self-checking bench for booth_mult_param
module tb_booth_mult_param;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sm;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic [15:0] res;
  logic        done;
  logic        busy;

  logic        start_s;
  logic        sm_s;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [3:0]  res2;
  logic [13:0] res7;
  logic [31:0] res16;
  logic        done2, done7, done16;
  logic        busy2, busy7, busy16;

  int checks = 0;
  int errors = 0;

  booth_mult_param #(.WIDTH(8)) dut (
    .clock(clk), .reset(rst_n), .start(start), .signed_mode(sm),
    .a_value(a_in), .b_value(b_in), .result(res), .done(done), .busy(busy)
  );

  booth_mult_param #(.WIDTH(2)) dut2 (
    .clock(clk), .reset(rst_n), .start(start_s), .signed_mode(sm_s),
    .a_value(a_s[1:0]), .b_value(b_s[1:0]), .result(res2), .done(done2), .busy(busy2)
  );

  booth_mult_param #(.WIDTH(7)) dut7 (
    .clock(clk), .reset(rst_n), .start(start_s), .signed_mode(sm_s),
    .a_value(a_s[6:0]), .b_value(b_s[6:0]), .result(res7), .done(done7), .busy(busy7)
  );

  booth_mult_param #(.WIDTH(16)) dut16 (
    .clock(clk), .reset(rst_n), .start(start_s), .signed_mode(sm_s),
    .a_value(a_s[15:0]), .b_value(b_s[15:0]), .result(res16), .done(done16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain integer arithmetic on the interpreted operand values.
  function automatic logic [63:0] ref_prod(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic signed_op);
    logic [63:0] mask;
    longint x, y, p;
    mask = (64'd1 << w) - 64'd1;
    x = longint'({32'd0, a} & mask);
    y = longint'({32'd0, b} & mask);
    if (signed_op && x[w-1]) x = x - (longint'(1) << w);
    if (signed_op && y[w-1]) y = y - (longint'(1) << w);
    p = x * y;
    return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Called at a negedge; returns after done is seen (or timeout) with start low.
  task automatic run_op(input logic s_mode, input logic [7:0] a, input logic [7:0] b, input bit noise,
                        output logic [15:0] r, output int lat, output int bc);
    start = 1'b1; sm = s_mode; a_in = a; b_in = b;
    @(negedge clk);
    lat = 0;
    bc  = 0;
    chk("done_low_after_start", {63'd0, done}, 64'd0);
    while (!done && lat < 40) begin
      if (busy) bc++;
      if (noise) begin
        start = 1'($urandom);
        sm    = 1'($urandom);
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    r = res;
    chk("busy_low_in_done", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    string       name;
    logic        s_mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] r;
    logic [15:0] held;
    logic [63:0] e;
    int lat, bc;

    vecs[0] = '{"s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1] = '{"s_7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080};
    vecs[2] = '{"s_FFx01", 1'b1, 8'hFF, 8'h01, 16'hFFFF};
    vecs[3] = '{"u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4] = '{"u_80x02", 1'b0, 8'h80, 8'h02, 16'h0100};
    vecs[5] = '{"u_00xAB", 1'b0, 8'h00, 8'hAB, 16'h0000};

    rst_n = 1'b0; start = 1'b0; sm = 1'b0; a_in = '0; b_in = '0;
    start_s = 1'b0; sm_s = 1'b0; a_s = '0; b_s = '0;
    #1;
    chk("reset_result", {48'd0, res}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_done", {63'd0, done}, 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].s_mode, vecs[i].a, vecs[i].b, 1'b0, r, lat, bc);
      chk({vecs[i].name, "_result"}, {48'd0, r}, {48'd0, vecs[i].exp});
      chk({vecs[i].name, "_latency"}, 64'(lat), 64'd9);
      chk({vecs[i].name, "_busy_cycles"}, 64'(bc), 64'd9);
    end

    // Inputs churn during RUN; result must reflect only the operands captured at start.
    run_op(1'b1, 8'h7F, 8'h80, 1'b1, r, lat, bc);
    chk("noise_result", {48'd0, r}, 64'hC080);
    chk("noise_latency", 64'(lat), 64'd9);
    chk("noise_busy_cycles", 64'(bc), 64'd9);
    held = res;
    repeat (5) @(negedge clk);
    chk("done_held", {63'd0, done}, 64'd1);
    chk("result_held", {48'd0, res}, {48'd0, held});

    run_op(1'b0, 8'd3, 8'd5, 1'b0, r, lat, bc);
    chk("restart_result", {48'd0, r}, 64'h000F);
    chk("restart_latency", 64'(lat), 64'd9);

    // Asynchronous reset 4 cycles into RUN.
    start = 1'b1; sm = 1'b1; a_in = 8'h55; b_in = 8'h66;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_result", {48'd0, res}, 64'd0);
    chk("midreset_done", {63'd0, done}, 64'd0);
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle_busy", {63'd0, busy}, 64'd0);
    run_op(1'b0, 8'h12, 8'h34, 1'b0, r, lat, bc);
    chk("post_reset_result", {48'd0, r}, 64'h03A8);
    chk("post_reset_latency", 64'(lat), 64'd9);

    for (int t = 0; t < 25; t++) begin
      logic s_mode;
      logic [7:0] a, b;
      s_mode = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      run_op(s_mode, a, b, 1'b0, r, lat, bc);
      chk("rand8_result", {48'd0, r}, ref_prod(8, {24'd0, a}, {24'd0, b}, s_mode));
      chk("rand8_latency", 64'(lat), 64'd9);
    end

    // Width sweep: all three widths start together and finish at their own W1.
    for (int t = 0; t < 20; t++) begin
      start_s = 1'b1;
      sm_s = 1'($urandom);
      a_s  = $urandom;
      b_s  = $urandom;
      @(negedge clk);
      start_s = 1'b0;
      for (int j = 0; j <= 17; j++) begin
        chk("w2_done", {63'd0, done2}, {63'd0, (j >= 3)});
        chk("w7_done", {63'd0, done7}, {63'd0, (j >= 8)});
        chk("w16_done", {63'd0, done16}, {63'd0, (j >= 17)});
        chk("w16_busy", {63'd0, busy16}, {63'd0, (j < 17)});
        if (j == 3) begin
          e = ref_prod(2, a_s, b_s, sm_s);
          chk("w2_result", {60'd0, res2}, e);
        end
        if (j == 8) begin
          e = ref_prod(7, a_s, b_s, sm_s);
          chk("w7_result", {50'd0, res7}, e);
        end
        if (j == 17) begin
          e = ref_prod(16, a_s, b_s, sm_s);
          chk("w16_result", {32'd0, res16}, e);
        end
        if (j < 17) @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_param.md
# booth_mult_param

Parametrised sequential radix-2 Booth multiplier. It is the next-generation replacement for the fixed 7-bit controller/datapath multiplier, with configurable operand width, a runtime signed/unsigned mode select, a busy flag, and back-to-back restart from the done state. It sits beside the existing arithmetic units and uses the same start/done handshake. The FSM and the datapath live in one module.

## Interface
- WIDTH, default 8: operand width in bits; legal range is 2 to 32.
- clock  in  1  rising-edge clock; the only clock.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- signed_mode  in  1  1 treats operands as two's complement, 0 as unsigned; sampled with start.
- a_value  in  WIDTH  multiplicand; sampled with start.
- b_value  in  WIDTH  multiplier; sampled with start.
- result  out  2*WIDTH  product; registered; holds its value until the next completion.
- done  out  1  level; high in DONE.
- busy  out  1  level; high in RUN.

## Operation
- W1 = WIDTH+1. Both operands are extended to W1 bits at start:
  - sign-extended when signed_mode=1;
  - zero-extended when signed_mode=0.
- Internal registers:
  - M (W1 bits): extended a_value.
  - A (W1 bits): accumulator, cleared to 0 at start.
  - Q (W1 bits): extended b_value.
  - q_m1 (1 bit): cleared to 0 at start.
  - count: ceil(log2(W1+1)) bits.
- Each RUN cycle performs one step, all modulo 2^W1:
  - {Q[0],q_m1}=01: A=A+M.
  - {Q[0],q_m1}=10: A=A−M.
  - 00 or 11: A unchanged.
  - Then {A,Q,q_m1} is arithmetic-shifted right by 1, with A's MSB replicated.
- After W1 steps, {A,Q} holds the 2*W1-bit product. result = {A,Q}[2*WIDTH-1:0].
  - The range is exact for both modes, with no overflow possible.
- FSM states:
  - IDLE, reset state: start=1 loads the operands, clears count, and goes to RUN.
  - RUN: performs one step per cycle and increments count. On the step where count=W1−1, it writes result and goes to DONE.
  - DONE: start=1 loads the new operands and goes to RUN, dropping done on the same edge. start=0 stays in DONE.
- start, a_value, b_value and signed_mode are ignored while in RUN. Changing the inputs mid-operation does not affect the result.
- Reset asserted at any time:
  - state goes to IDLE;
  - result=0, done=0, busy=0;
  - any in-flight operation is discarded;
  - no output glitches to a partial product.

## Timing
- Reset values: result=0, done=0, busy=0, state=IDLE.
- Let edge k be the edge that samples start=1 in IDLE or DONE.
  - busy=1 from after edge k until after edge k+W1.
  - result updates and done=1 after edge k+W1, a latency of WIDTH+1 cycles.
  - busy and done are never both high.
- done stays high and result stays stable for as long as start=0.
- Back-to-back operation: start held high continuously gives one product every W1+1 cycles.
- Reset deassertion is not synchronised internally. The integrating block guarantees that deassertion is clean relative to clock.

## Test plan
All scenarios use WIDTH=8 unless noted.
- Signed corners:
  - signed_mode=1, a=0x80, b=0x80 -> result=0x4000, done after exactly 9 cycles.
  - a=0x7F, b=0x80 -> 0xC080.
  - a=0xFF, b=0x01 -> 0xFFFF.
- Unsigned corners:
  - signed_mode=0, a=0xFF, b=0xFF -> 0xFE01.
  - a=0x80, b=0x02 -> 0x0100.
  - a=0, b=0xAB -> 0x0000.
- Handshake:
  - During RUN, toggle start and change a/b/signed_mode -> first result unaffected; busy exactly 9 cycles; done held until the next start.
  - From DONE, start with a=3, b=5 -> done drops on that edge; 0x000F appears 9 cycles later.
- Reset mid-operation: assert reset 4 cycles into RUN -> outputs go to 0 immediately and state returns to IDLE. A following start with a=0x12, b=0x34, unsigned -> 0x03A8.
- Width sweep: WIDTH=2, 7 and 16, random operands in both modes versus a reference product -> all match, with latency WIDTH+1 in every case.
